videoram_scanout: RTL and testbench

Reads the 1-bpp framebuffer held in the Nios system's video RAM and drives a 640x480@60 Hz VGA output. The block is the downstream consumer of the video RAM: the Nios CPU writes barcode and graphics data through the Avalon side, and this block owns the external video RAM port as a read-only master. A 512x256 pixel window is centred in the 640x480 active area; everything outside the window is drawn as border.

---
 rtl/videoram_scanout.sv | 205 ++++++++++++++++++++
 tb/tb_videoram_scanout.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/videoram_scanout.sv
// videoram_scanout: 640x480 VGA scan-out of a centred 512x256 1-bpp window read from video RAM.
// Single 50 MHz clock; all video timing and the pixel pipeline advance on a divide-by-two pixel enable.
module videoram_scanout #(
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'h00F,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          WIN_ROW0     = 112,
  parameter int          WIN_ROWS     = 256
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        display_en,
  output logic [11:0] videoram_address,
  output logic        videoram_chipselect,
  output logic        videoram_clken,
  output logic        videoram_write,
  output logic [31:0] videoram_writedata,
  output logic [3:0]  videoram_byteenable,
  input  logic [31:0] videoram_readdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank_n,
  output logic        vga_clk_en,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] H_ACT      = 10'd640;
  localparam logic [9:0] H_SYNC_S   = 10'd656;
  localparam logic [9:0] H_SYNC_E   = 10'd752;
  localparam logic [9:0] H_PREFETCH = 10'd48;
  localparam logic [9:0] H_WIN_S    = 10'd64;
  localparam logic [9:0] H_WIN_E    = 10'd576;
  localparam logic [9:0] H_LAST_REQ = 10'd512;
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_S   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_WIN_S    = 10'(WIN_ROW0);
  localparam logic [9:0] V_WIN_E    = 10'(WIN_ROW0 + WIN_ROWS);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, CAP = 2'd2} fetch_state_t;

  logic         pix_ce;
  logic [9:0]   hcount, vcount;
  logic         win_en;
  fetch_state_t state, state_next;
  logic [31:0]  nxt, sh, sh_next;
  logic         nxt_valid;
  logic [11:0]  rgb, colour;
  logic         h_active, v_active, hsync_now, vsync_now;
  logic         win_row, win_col, in_window, frame_pt;
  logic         fetch_go, load_go, shift_go;
  logic [3:0]   fetch_word;
  logic [7:0]   row;

  assign videoram_clken      = 1'b1;
  assign videoram_write      = 1'b0;
  assign videoram_writedata  = 32'h0000_0000;
  assign videoram_byteenable = 4'hF;
  assign vga_clk_en          = pix_ce;
  assign vga_r               = rgb[11:8];
  assign vga_g               = rgb[7:4];
  assign vga_b               = rgb[3:0];

  assign h_active   = (hcount < H_ACT);
  assign v_active   = (vcount < V_ACT);
  assign hsync_now  = !((hcount >= H_SYNC_S) && (hcount < H_SYNC_E));
  assign vsync_now  = !((vcount >= V_SYNC_S) && (vcount < V_SYNC_E));
  assign win_row    = (vcount >= V_WIN_S) && (vcount < V_WIN_E);
  assign win_col    = (hcount >= H_WIN_S) && (hcount < H_WIN_E);
  assign in_window  = win_row && win_col;
  assign frame_pt   = pix_ce && (hcount == 10'd0) && (vcount == 10'd0);
  assign row        = 8'(vcount - V_WIN_S);
  // Word k+1 is requested at column 64+32k and word 0 at column 48, so the index is (h-32)/32.
  assign fetch_word = 4'((hcount - 10'd32) >> 5);
  assign fetch_go   = pix_ce && win_en && win_row &&
                      ((hcount == H_PREFETCH) ||
                       ((hcount[4:0] == 5'd0) && (hcount >= H_WIN_S) && (hcount <= H_LAST_REQ)));
  assign load_go    = pix_ce && win_en && in_window && (hcount[4:0] == 5'd0);
  assign shift_go   = pix_ce && win_en && in_window && (hcount[4:0] != 5'd0);

  // Pixel enable toggles every clock.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) pix_ce <= 1'b0;
    else                pix_ce <= ~pix_ce;
  end

  // Horizontal and vertical raster counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else if (pix_ce) begin
      if (hcount == H_LAST) begin
        hcount <= 10'd0;
        vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Window enable is only sampled at the start of a frame.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  win_en <= 1'b0;
    else if (frame_pt)   win_en <= display_en;
  end

  // Fetch FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_next;
  end

  // Fetch FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_go) state_next = REQ; else state_next = IDLE;
      REQ:     state_next = CAP;
      CAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered read strobe and address toward the video RAM.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      videoram_chipselect <= 1'b0;
      videoram_address    <= 12'h000;
    end else begin
      videoram_chipselect <= (state_next == REQ);
      if (fetch_go) videoram_address <= {row, fetch_word};
    end
  end

  // Next-word buffer; a shift-register load consumes it, a capture refills it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      nxt       <= 32'h0000_0000;
      nxt_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (load_go) begin
        nxt_valid <= 1'b0;
        if (!nxt_valid) underrun <= 1'b1;
      end
      if (state == CAP) begin
        nxt       <= videoram_readdata;
        nxt_valid <= 1'b1;
      end
    end
  end

  // Shift-register next value; its MSB is the pixel shown for the current column.
  always_comb begin
    sh_next = sh;
    if (load_go)       sh_next = nxt_valid ? nxt : 32'h0000_0000;
    else if (shift_go) sh_next = {sh[30:0], 1'b0};
    else               sh_next = sh;
  end

  // Pixel shift register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) sh <= 32'h0000_0000;
    else                sh <= sh_next;
  end

  // Colour for the pixel the counters currently hold.
  always_comb begin
    colour = 12'h000;
    if (!(h_active && v_active))  colour = 12'h000;
    else if (win_en && in_window) colour = sh_next[31] ? FG_COLOR : BG_COLOR;
    else                          colour = BORDER_COLOR;
  end

  // Video outputs, registered so sync, blank and colour stay aligned.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      rgb         <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_pt;
      if (pix_ce) begin
        vga_hsync   <= hsync_now;
        vga_vsync   <= vsync_now;
        vga_blank_n <= h_active && v_active;
        rgb         <= colour;
      end
    end
  end

endmodule

// File: tb/tb_videoram_scanout.sv
// Self-checking bench for videoram_scanout with a shortened vertical raster and a random video RAM image.
// Expected outputs come from the raster position implied by the number of clock edges since reset release.
module tb_videoram_scanout;

  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int WIN_ROW0 = 2;
  localparam int WIN_ROWS = 3;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = 800 * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        display_en = 1'b0;
  logic [11:0] videoram_address;
  logic        videoram_chipselect, videoram_clken, videoram_write;
  logic [31:0] videoram_writedata;
  logic [3:0]  videoram_byteenable;
  logic [31:0] videoram_readdata = 32'h0000_0000;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_blank_n, vga_clk_en, frame_start, underrun;

  logic [31:0] mem [0:4095];

  int          n = 0;
  int          errors = 0;
  int          checks = 0;
  logic        m_hs, m_vs, m_bl, m_fs, m_cs, m_win;
  logic [11:0] m_rgb, m_addr;

  videoram_scanout #(
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .WIN_ROW0(WIN_ROW0), .WIN_ROWS(WIN_ROWS)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .display_en(display_en),
    .videoram_address(videoram_address), .videoram_chipselect(videoram_chipselect),
    .videoram_clken(videoram_clken), .videoram_write(videoram_write),
    .videoram_writedata(videoram_writedata), .videoram_byteenable(videoram_byteenable),
    .videoram_readdata(videoram_readdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
    .vga_clk_en(vga_clk_en), .frame_start(frame_start), .underrun(underrun)
  );

  initial forever #10 clk = ~clk;

  // Video RAM: data valid for exactly one clock after the strobe, garbage otherwise.
  always @(posedge clk)
    videoram_readdata <= videoram_chipselect ? mem[videoram_address] : $urandom;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hs = 1'b1; m_vs = 1'b1; m_bl = 1'b0; m_rgb = 12'h000;
    m_fs = 1'b0; m_cs = 1'b0; m_addr = 12'h000; m_win = 1'b0;
    n = 0;
  endtask

  function automatic logic [11:0] pix_colour(input int h, input int v);
    logic [31:0] w;
    if (!(h < 640 && v < V_ACTIVE)) return 12'h000;
    if (m_win && h >= 64 && h < 576 && v >= WIN_ROW0 && v < WIN_ROW0 + WIN_ROWS) begin
      w = mem[(v - WIN_ROW0) * 16 + (h - 64) / 32];
      return w[31 - ((h - 64) % 32)] ? 12'hFFF : 12'h000;
    end
    return 12'h00F;
  endfunction

  task automatic check_all();
    check("video", {vga_hsync, vga_vsync, vga_blank_n, vga_r, vga_g, vga_b, frame_start, vga_clk_en},
                   {m_hs, m_vs, m_bl, m_rgb, m_fs, (n % 2 == 1)});
    check("fetch", {videoram_chipselect, videoram_address, underrun}, {m_cs, m_addr, 1'b0});
  endtask

  // One clock: the pixel whose outputs appear after edge n (n even) is step n/2-1 of the raster.
  task automatic tick();
    logic en_before;
    int p, h, v;
    en_before = display_en;
    @(posedge clk);
    n++;
    m_fs = 1'b0;
    m_cs = 1'b0;
    if (n >= 2 && n % 2 == 0) begin
      p = n / 2 - 1;
      h = p % 800;
      v = (p / 800) % VT;
      if (h == 0 && v == 0) begin
        m_win = en_before;
        m_fs  = 1'b1;
      end
      m_hs  = !(h >= 656 && h < 752);
      m_vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
      m_bl  = (h < 640 && v < V_ACTIVE);
      m_rgb = pix_colour(h, v);
      if (m_win && v >= WIN_ROW0 && v < WIN_ROW0 + WIN_ROWS &&
          (h == 48 || (h >= 64 && h <= 512 && h % 32 == 0))) begin
        m_cs   = 1'b1;
        m_addr = 12'((v - WIN_ROW0) * 16 + ((h == 48) ? 0 : (h - 64) / 32 + 1));
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[0] = 32'h8000_0001;
    for (int i = 1; i < 16; i++) mem[i] = 32'h0000_0000;

    #1 rst_n = 1'b0;
    display_en = 1'b1;
    model_reset();
    repeat (3) begin @(posedge clk); #1; check_all(); end
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: window enabled at frame start, display_en then wanders without effect.
    while (n < 2) tick();
    while (n < 2 * FRAME - 10) begin display_en = 1'($urandom_range(0, 1)); tick(); end
    display_en = 1'b0;
    while (n < 2 * FRAME + 4) tick();

    // Frame 1: window disabled; reset lands mid-cycle after pixel (h=300, v=5).
    while (n < 2 * (FRAME + 5 * 800 + 300 + 1)) begin
      display_en = 1'($urandom_range(0, 1));
      tick();
    end
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    repeat (3) begin @(posedge clk); #1; check_all(); end
    display_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Restart from (0,0) with the window enabled, then into the following frame.
    while (n < 2 * FRAME + 3200) begin
      if (n >= 2) display_en = 1'($urandom_range(0, 1));
      tick();
    end

    check("const", {videoram_clken, videoram_write, videoram_writedata, videoram_byteenable},
                   {1'b1, 1'b0, 32'h0000_0000, 4'hF});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
